a2n_frame_tx: RTL and testbench
===============================

Name: a2n_frame_tx

Overview:
Transmit end of the A2N serial link. Models the acquisition ASIC side that drives A2N_VALID/A2N_DATA into the FPGA receiver. Accepts parallel sample words over a valid/ready handshake. Serializes each word MSB-first with an optional even-parity bit and a bit clock, and inserts an idle gap between frames. Used as the link-side stimulus generator in top-level benches and as the loopback transmitter in link self-test builds.

Parameters:
DATA_W, 16, data bits per frame (2..32)
CLK_DIV, 4, SYSCLK cycles per bit period; even, >= 2
GAP_BITS, 2, bit periods with A2N_VALID low after each frame (0..15)
PARITY_EN, 1, 1 = append one even-parity bit after the data bits

Ports:
SYSCLK  in  1  system clock; all logic on the rising edge
NSYSRESET  in  1  asynchronous, active-low reset
tx_data  in  DATA_W  word to send
tx_valid  in  1  tx_data is valid
tx_ready  out  1  block can accept a word this cycle
A2N_VALID  out  1  high for every data and parity bit period of a frame
A2N_DATA  out  1  serial bit, MSB first
A2N_BCLK  out  1  bit clock; the receiver samples A2N_DATA on its rising edge
busy  out  1  state != IDLE
frames_sent  out  16  count of completed frames; wraps 0xFFFF -> 0x0000

Behaviour:
- Reset, asynchronous on NSYSRESET low:
  - State = IDLE.
  - tx_ready, A2N_VALID, A2N_DATA, A2N_BCLK, busy = 0.
  - frames_sent = 0.
  - Shift register, bit counter and divider counter = 0.
- First rising edge after NSYSRESET goes high: tx_ready = 1. All outputs are registered.
- States: IDLE, SHIFT, PARITY, GAP.
- IDLE:
  - tx_ready = 1.
  - On tx_valid && tx_ready at an edge: latch tx_data, compute parity = XOR of all data bits, clear the divider and bit counter, go to SHIFT, set tx_ready = 0.
- SHIFT:
  - A2N_VALID = 1 from the first cycle after acceptance.
  - Bit i (MSB first) is held for exactly CLK_DIV cycles.
  - A2N_BCLK = 0 for the first CLK_DIV/2 cycles of each bit and 1 for the remaining CLK_DIV/2 cycles.
  - After DATA_W bits: go to PARITY if PARITY_EN, else to GAP.
- PARITY: one bit period. A2N_DATA = parity, so the total count of ones over data plus parity is even. A2N_VALID = 1 and A2N_BCLK follows the same pattern as in SHIFT.
- End of the last data/parity bit: frames_sent += 1 (modulo 2^16).
- GAP:
  - A2N_VALID = 0, A2N_DATA = 0, A2N_BCLK = 0 for GAP_BITS*CLK_DIV cycles, then IDLE.
  - GAP_BITS = 0: go directly to IDLE.
- Frame timing: A2N_VALID is high for (DATA_W+PARITY_EN)*CLK_DIV consecutive cycles. tx_ready reasserts (DATA_W+PARITY_EN+GAP_BITS)*CLK_DIV cycles after the acceptance edge.
- tx_data and tx_valid are ignored while tx_ready = 0. The latched word is unaffected by input changes mid-frame.
- A2N_BCLK, A2N_DATA and A2N_VALID transition only at bit boundaries or half-bit points, and are glitch-free.
- busy = 1 in SHIFT, PARITY and GAP.
- Reset mid-frame: all outputs clear immediately and the partial frame is not counted.

Test Plan:
- Default parameters, send 0xA5C3:
  - A2N_DATA reads 1010010111000011 then parity 0, one bit per 4 cycles.
  - A2N_VALID is high for exactly 68 cycles.
  - tx_ready returns 76 cycles after acceptance.
  - frames_sent = 1.
- Send 0x0001: parity bit = 1. Send 0x0000: parity bit = 0, A2N_DATA low for the entire frame while A2N_VALID = 1.
- Hold tx_valid = 1 with words 0x1234 then 0x5678 (second word presented while busy):
  - Only 0x1234 is sent first.
  - 0x5678 is accepted on the first IDLE edge; A2N_VALID stays low for 8 cycles between frames.
  - frames_sent = 2.
- PARITY_EN=0, GAP_BITS=0, CLK_DIV=2, send 0xFFFF: A2N_VALID is high for 32 cycles and A2N_BCLK toggles every cycle. No GAP state is entered; tx_ready returns 32 cycles after acceptance.
- Assert NSYSRESET low during bit 5 of 0xA5C3:
  - All outputs go to 0 without waiting for a clock edge, and frames_sent = 0.
  - After release, tx_ready = 1 on the next edge and a new 0x00FF frame transmits correctly.
- Change tx_data every cycle during a frame: the serialized bits match the word latched at acceptance.

Source files
------------

// File: rtl/a2n_frame_tx.sv
// A2N link transmitter: serializes handshaked parallel words MSB-first with optional
// even parity and a half-duty bit clock, then holds the link idle for a fixed gap.
module a2n_frame_tx #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int GAP_BITS  = 2,
  parameter int PARITY_EN = 1
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              A2N_VALID,
  output logic              A2N_DATA,
  output logic              A2N_BCLK,
  output logic              busy,
  output logic [15:0]       frames_sent
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = 6;
  localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_DIV  = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam bit HAS_PARITY = (PARITY_EN != 0);
  localparam bit HAS_GAP    = (GAP_BITS > 0);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par, par_n;
  logic [CNT_W-1:0]  bit_cnt, bit_n;
  logic [DIV_W-1:0]  div, div_n;
  logic              last_div, accept, count_en, final_n;
  logic              ready_n, valid_n, data_n, bclk_n;

  always_comb begin
    // NOTE: every value written here gets a default first, so no path can infer a latch.
    state_n  = state;
    shreg_n  = shreg;
    par_n    = par;
    bit_n    = bit_cnt;
    div_n    = div;
    count_en = 1'b0;
    last_div = (div == LAST_DIV);
    accept   = tx_valid && tx_ready;

    case (state)
      SHIFT: begin
        if (!last_div) begin
          div_n = div + 1'b1;
        end else begin
          div_n = '0;
          if (bit_cnt != LAST_DATA) begin
            bit_n   = bit_cnt + 1'b1;
            shreg_n = shreg << 1;
          end else begin
            bit_n = '0;
            if (HAS_PARITY) begin
              state_n = PARITY;
            end else begin
              count_en = 1'b1;
              state_n  = HAS_GAP ? GAP : IDLE;
            end
          end
        end
      end
      PARITY: begin
        if (!last_div) begin
          div_n = div + 1'b1;
        end else begin
          div_n    = '0;
          count_en = 1'b1;
          state_n  = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP: begin
        if (!last_div) begin
          div_n = div + 1'b1;
        end else begin
          div_n = '0;
          if (bit_cnt != LAST_GAP) begin
            bit_n = bit_cnt + 1'b1;
          end else begin
            bit_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: ;
    endcase

    // A word accepted on the final cycle of a frame starts the next frame back-to-back.
    if (accept) begin
      state_n = SHIFT;
      shreg_n = tx_data;
      par_n   = ^tx_data;
      bit_n   = '0;
      div_n   = '0;
    end

    valid_n = (state_n == SHIFT) || (state_n == PARITY);
    data_n  = (state_n == SHIFT) ? shreg_n[DATA_W-1] : ((state_n == PARITY) && par_n);
    bclk_n  = valid_n && (div_n >= HALF_DIV);

    // tx_ready is registered, so it rises for the last cycle of the frame; a word offered
    // then is taken on the edge that ends the frame, leaving no dead cycle between frames.
    if (HAS_GAP)
      final_n = (state_n == GAP) && (bit_n == LAST_GAP) && (div_n == LAST_DIV);
    else if (HAS_PARITY)
      final_n = (state_n == PARITY) && (div_n == LAST_DIV);
    else
      final_n = (state_n == SHIFT) && (bit_n == LAST_DATA) && (div_n == LAST_DIV);
    ready_n = (state_n == IDLE) || final_n;
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state       <= IDLE;
      shreg       <= '0;
      par         <= 1'b0;
      bit_cnt     <= '0;
      div         <= '0;
      tx_ready    <= 1'b0;
      A2N_VALID   <= 1'b0;
      A2N_DATA    <= 1'b0;
      A2N_BCLK    <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values.
      state     <= state_n;
      shreg     <= shreg_n;
      par       <= par_n;
      bit_cnt   <= bit_n;
      div       <= div_n;
      tx_ready  <= ready_n;
      A2N_VALID <= valid_n;
      A2N_DATA  <= data_n;
      A2N_BCLK  <= bclk_n;
      busy      <= (state_n != IDLE);
      if (count_en)
        frames_sent <= frames_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_a2n_frame_tx.sv
// Bench for a2n_frame_tx: two configurations, table vectors, random frames checked cycle
// by cycle against a frame-timing model, and an asynchronous reset in mid-frame.
module tb_a2n_frame_tx;

  logic        sysclk = 1'b0;
  logic        nsysreset = 1'b1;
  logic [15:0] drv_data = '0;
  logic        drv_valid = 1'b0;
  int          sel = 0;

  always #5 sysclk = ~sysclk;

  logic        tx_valid0, tx_valid1;
  logic        d0_ready, d0_valid, d0_data, d0_bclk, d0_busy;
  logic        d1_ready, d1_valid, d1_data, d1_bclk, d1_busy;
  logic [15:0] d0_frames, d1_frames;

  assign tx_valid0 = drv_valid && (sel == 0);
  assign tx_valid1 = drv_valid && (sel == 1);

  a2n_frame_tx #(.DATA_W(16), .CLK_DIV(4), .GAP_BITS(2), .PARITY_EN(1)) dut0 (
    .SYSCLK(sysclk), .NSYSRESET(nsysreset), .tx_data(drv_data), .tx_valid(tx_valid0),
    .tx_ready(d0_ready), .A2N_VALID(d0_valid), .A2N_DATA(d0_data), .A2N_BCLK(d0_bclk),
    .busy(d0_busy), .frames_sent(d0_frames));

  a2n_frame_tx #(.DATA_W(16), .CLK_DIV(2), .GAP_BITS(0), .PARITY_EN(0)) dut1 (
    .SYSCLK(sysclk), .NSYSRESET(nsysreset), .tx_data(drv_data), .tx_valid(tx_valid1),
    .tx_ready(d1_ready), .A2N_VALID(d1_valid), .A2N_DATA(d1_data), .A2N_BCLK(d1_bclk),
    .busy(d1_busy), .frames_sent(d1_frames));

  logic        o_ready, o_valid, o_data, o_bclk, o_busy;
  logic [15:0] o_frames;

  always_comb begin
    if (sel == 0) {o_ready, o_valid, o_data, o_bclk, o_busy, o_frames} =
                    {d0_ready, d0_valid, d0_data, d0_bclk, d0_busy, d0_frames};
    else          {o_ready, o_valid, o_data, o_bclk, o_busy, o_frames} =
                    {d1_ready, d1_valid, d1_data, d1_bclk, d1_busy, d1_frames};
  end

  int cd_cfg  [2] = '{4, 2};
  int pe_cfg  [2] = '{1, 0};
  int gap_cfg [2] = '{2, 0};
  int exp_frames [2] = '{0, 0};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends one word on the selected DUT and checks every cycle of the frame against the
  // link timing rules. Inputs are scrambled while the frame is in flight.
  task automatic run_frame(input logic [15:0] word, input bit chain, input logic [15:0] next_word,
                           input int stop_k, output logic [16:0] cap, output int nvalid,
                           output int ready_at);
    int cdv, nb, t, bad, first_bad, bi;
    logic exp_bit;
    logic [20:0] exp_vec, act_vec;
    cdv = cd_cfg[sel];
    nb  = 16 + pe_cfg[sel];
    t   = (nb + gap_cfg[sel]) * cdv;
    cap = '0; nvalid = 0; ready_at = -1; bad = 0; first_bad = -1;

    for (int w = 0; w < 200 && !o_ready; w++) @(negedge sysclk);
    check($sformatf("ready_before_accept sel=%0d", sel), {31'd0, o_ready}, 32'd1);
    if (!o_ready) return;

    drv_data  = word;
    drv_valid = 1'b1;
    @(posedge sysclk);
    for (int k = 0; k < t; k++) begin
      @(negedge sysclk);
      bi = k / cdv;
      if (bi < 16)      exp_bit = word[15 - bi];
      else if (bi < nb) exp_bit = ($countones(word) % 2) == 1;
      else              exp_bit = 1'b0;
      exp_vec = {(k == t - 1), (k < nb * cdv), exp_bit,
                 (k < nb * cdv) && ((k % cdv) >= cdv / 2), 1'b1,
                 16'(exp_frames[sel] + ((k >= nb * cdv) ? 1 : 0))};
      act_vec = {o_ready, o_valid, o_data, o_bclk, o_busy, o_frames};
      if (act_vec !== exp_vec) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (o_valid) nvalid++;
      if (o_ready && ready_at < 0) ready_at = k + 1;
      if ((k % cdv) == cdv - 1 && k < nb * cdv) cap = {cap[15:0], o_data};
      if (k == stop_k) break;
      if (k == t - 1) begin
        drv_data  = chain ? next_word : 16'($urandom);
        drv_valid = chain;
      end else begin
        drv_data  = 16'($urandom);
        drv_valid = 1'($urandom % 2);
      end
    end
    check($sformatf("frame_wave sel=%0d word=%h first_bad_cycle=%0d", sel, word, first_bad),
          bad, 0);
    if (stop_k < 0) exp_frames[sel]++;
  endtask

  typedef struct {
    logic [15:0] word;
    logic [16:0] stream;
    bit          chain;
  } vec_t;

  initial begin
    vec_t vecs [6];
    logic [16:0] cap, ecap;
    logic [15:0] cur, nxt;
    int nv, ra, nb;
    bit ch;

    vecs[0] = '{16'hA5C3, {16'hA5C3, 1'b0}, 1'b0};
    vecs[1] = '{16'h0001, {16'h0001, 1'b1}, 1'b0};
    vecs[2] = '{16'h0000, {16'h0000, 1'b0}, 1'b0};
    vecs[3] = '{16'h1234, {16'h1234, 1'b1}, 1'b1};
    vecs[4] = '{16'h5678, {16'h5678, 1'b0}, 1'b0};
    vecs[5] = '{16'h8000, {16'h8000, 1'b1}, 1'b0};

    #1 nsysreset = 1'b0;
    #1;
    check("reset_outputs_d0", {d0_ready, d0_valid, d0_data, d0_bclk, d0_busy, d0_frames}, 0);
    check("reset_outputs_d1", {d1_ready, d1_valid, d1_data, d1_bclk, d1_busy, d1_frames}, 0);
    repeat (2) @(negedge sysclk);
    nsysreset = 1'b1;
    check("ready_low_before_first_edge", {31'd0, d0_ready}, 0);
    @(posedge sysclk);
    #1 check("ready_after_first_edge", {30'd0, d0_ready, d1_ready}, 32'h3);
    @(negedge sysclk);

    // Table vectors on the parity/gap configuration; 0x1234 chains straight into 0x5678.
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].word, vecs[i].chain, (i < 5) ? vecs[i + 1].word : 16'h0, -1, cap, nv, ra);
      check($sformatf("vec%0d_stream", i), {15'd0, cap}, {15'd0, vecs[i].stream});
      check($sformatf("vec%0d_valid_cycles", i), nv, 68);
      check($sformatf("vec%0d_ready_return", i), ra, 76);
      if (i == 0) check("frames_after_first", {16'd0, d0_frames}, 1);
    end
    repeat (3) @(negedge sysclk);
    check("frames_after_table", {16'd0, d0_frames}, 32'(exp_frames[0]));
    check("idle_after_table", {d0_ready, d0_valid, d0_data, d0_bclk, d0_busy}, 5'b10000);

    // No parity, no gap, divide-by-two configuration.
    sel = 1;
    run_frame(16'hFFFF, 1'b0, 16'h0, -1, cap, nv, ra);
    check("d1_ffff_stream", {16'd0, cap[15:0]}, 32'h0000FFFF);
    check("d1_ffff_valid_cycles", nv, 32);
    check("d1_ffff_ready_return", ra, 32);
    @(negedge sysclk);
    check("d1_frames_after_ffff", {16'd0, d1_frames}, 1);

    // Random words, random back-to-back chaining, on both configurations.
    for (int d = 0; d < 2; d++) begin
      sel = d;
      nb  = (16 + pe_cfg[d]) * cd_cfg[d];
      cur = 16'($urandom);
      for (int i = 0; i < 8; i++) begin
        nxt = 16'($urandom);
        ch  = (i < 7) && ($urandom % 2 == 1);
        run_frame(cur, ch, nxt, -1, cap, nv, ra);
        if (pe_cfg[d] != 0) ecap = {cur, ($countones(cur) % 2) == 1};
        else                ecap = {1'b0, cur};
        check($sformatf("rand_stream sel=%0d word=%h", d, cur), {15'd0, cap}, {15'd0, ecap});
        check($sformatf("rand_valid_cycles sel=%0d", d), nv, nb);
        if (!ch) repeat ($urandom % 4) @(negedge sysclk);
        cur = nxt;
      end
      repeat (2) @(negedge sysclk);
      check($sformatf("rand_frames sel=%0d", d), {16'd0, o_frames}, 32'(exp_frames[d]));
    end

    // Asynchronous reset during bit 5 of 0xA5C3; the partial frame is not counted.
    sel = 0;
    run_frame(16'hA5C3, 1'b0, 16'h0, 21, cap, nv, ra);
    #2 nsysreset = 1'b0;
    drv_valid = 1'b0;
    #1;
    check("midframe_reset_outputs", {d0_ready, d0_valid, d0_data, d0_bclk, d0_busy, d0_frames}, 0);
    check("midframe_reset_d1_frames", {16'd0, d1_frames}, 0);
    exp_frames = '{0, 0};
    repeat (2) @(negedge sysclk);
    nsysreset = 1'b1;
    check("ready_low_after_release", {31'd0, d0_ready}, 0);
    @(posedge sysclk);
    #1 check("ready_after_release_edge", {31'd0, d0_ready}, 1);
    @(negedge sysclk);
    run_frame(16'h00FF, 1'b0, 16'h0, -1, cap, nv, ra);
    check("post_reset_00ff_stream", {15'd0, cap}, {15'd0, 16'h00FF, 1'b0});
    check("post_reset_ready_return", ra, 76);
    repeat (2) @(negedge sysclk);
    check("post_reset_frames", {16'd0, d0_frames}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
